// File: rtl/q_frag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | q_frag_pkg : shared types and constants for the q_frag_arb arbiter   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package q_frag_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'b00,
    SET    = 2'b01,
    CLR    = 2'b10,
    RECIRC = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    ACK   = 2'b10
  } state_t;

  localparam int LOCK_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/q_frag_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | q_frag_rr_pick : combinational round-robin picker starting at i_ptr  |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module q_frag_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  input  logic [NREQ-1:0] i_mask,
  output logic [NREQ-1:0] o_win_oh,
  output logic [PW-1:0]   o_win_idx
);

  logic [NREQ-1:0] w_elig;
  logic [PW:0]     w_sum;
  logic [PW-1:0]   w_idx;
  logic            w_found;

  assign w_elig = i_req & ~i_mask;

  // Walk ptr, ptr+1, ... wrapping at NREQ (NREQ need not be a power of two).
  always_comb begin
    o_win_oh  = '0;
    o_win_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end
      w_idx = w_sum[PW-1:0];
      if (!w_found && w_elig[w_idx]) begin
        w_found          = 1'b1;
        o_win_oh[w_idx]  = 1'b1;
        o_win_idx        = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/q_frag_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | q_frag_arb : round-robin arbiter sharing one logic-cell FF bank      |
// |              optional grant-hold feature: Q_FRAG_ARB_LOCK_EN         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module q_frag_arb
  import q_frag_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                    QCK,
  input  logic                    QRT,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   wdata,
`ifdef Q_FRAG_ARB_LOCK_EN
  input  logic [NREQ-1:0]         lock,
`endif
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic                    q_en,
  output logic                    q_ds,
  output logic                    q_st,
  output logic                    q_rt,
  output logic [WIDTH-1:0]        q_di
);

  localparam int PW = $clog2(NREQ);

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [NREQ-1:0] r_win_oh;
  logic [PW-1:0]   r_win_idx;
  logic            r_regrant;

  logic [NREQ-1:0] r_gnt, r_ack, w_gnt_nxt, w_ack_nxt;
  logic            r_en, r_ds, r_st, r_rt;
  logic            w_en_nxt, w_ds_nxt, w_st_nxt, w_rt_nxt;
  logic [WIDTH-1:0] r_di, w_di_nxt;

  logic [NREQ-1:0] w_mask, w_pick_oh, w_sel_oh;
  logic [PW-1:0]   w_pick_idx, w_sel_idx;
  logic            w_regrant, w_start;
  op_t             w_sel_op;
  logic [WIDTH-1:0] w_sel_data;

  assign w_start = ((r_state == IDLE) || (r_state == ACK)) && (|req);

  // Last winner sits out the ACK-cycle arbitration only while someone else waits.
  assign w_mask = ((r_state == ACK) && (|(req & ~r_win_oh))) ? r_win_oh : '0;

  q_frag_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .i_mask    (w_mask),
    .o_win_oh  (w_pick_oh),
    .o_win_idx (w_pick_idx)
  );

`ifdef Q_FRAG_ARB_LOCK_EN
  logic [1:0] r_lock_cnt;

  assign w_regrant = (r_state == ACK) && (|(req & lock & r_win_oh)) &&
                     (r_lock_cnt != 2'(LOCK_MAX-1));

  always_ff @(posedge QCK) begin
    if (QRT) begin
      r_lock_cnt <= '0;
    end else if (w_start) begin
      r_lock_cnt <= w_regrant ? r_lock_cnt + 2'd1 : 2'd0;
    end
  end
`else
  assign w_regrant = 1'b0;
`endif

  assign w_sel_oh  = w_regrant ? r_win_oh  : w_pick_oh;
  assign w_sel_idx = w_regrant ? r_win_idx : w_pick_idx;

  always_comb begin
    w_sel_op   = LOAD;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel_oh[i]) begin
        w_sel_op   = op_t'(op[2*i +: 2]);
        w_sel_data = wdata[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = '0;
    w_ack_nxt   = '0;
    w_en_nxt    = 1'b0;
    w_ds_nxt    = 1'b0;
    w_st_nxt    = 1'b0;
    w_rt_nxt    = 1'b0;
    w_di_nxt    = '0;
    case (r_state)
      IDLE, ACK: begin
        if (w_start) begin
          w_state_nxt = ISSUE;
          w_gnt_nxt   = w_sel_oh;
          case (w_sel_op)
            LOAD: begin
              w_en_nxt = 1'b1;
              w_ds_nxt = 1'b1;
              w_di_nxt = w_sel_data;
            end
            SET:    w_st_nxt = 1'b1;
            CLR:    w_rt_nxt = 1'b1;
            RECIRC: w_en_nxt = 1'b1;
          endcase
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        w_state_nxt = ACK;
        w_ack_nxt   = r_win_oh;
        if (!r_regrant) begin
          w_ptr_nxt = (r_win_idx == PW'(NREQ-1)) ? '0 : r_win_idx + PW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge QCK) begin
    if (QRT) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_win_oh  <= '0;
      r_win_idx <= '0;
      r_regrant <= 1'b0;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_en      <= 1'b0;
      r_ds      <= 1'b0;
      r_st      <= 1'b0;
      r_rt      <= 1'b0;
      r_di      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ack   <= w_ack_nxt;
      r_en    <= w_en_nxt;
      r_ds    <= w_ds_nxt;
      r_st    <= w_st_nxt;
      r_rt    <= w_rt_nxt;
      r_di    <= w_di_nxt;
      if (w_start) begin
        r_win_oh  <= w_sel_oh;
        r_win_idx <= w_sel_idx;
        r_regrant <= w_regrant;
      end
    end
  end

  assign gnt  = r_gnt;
  assign ack  = r_ack;
  assign busy = (r_state != IDLE);
  assign q_en = r_en;
  assign q_ds = r_ds;
  assign q_st = r_st;
  assign q_rt = r_rt;
  assign q_di = r_di;

endmodule
`default_nettype wire

// File: doc/q_frag_arb.md
Q_FRAG_ARB -- requirements
Module: q_frag_arb

Interface
REQ-001 Parameter WIDTH, default 8: number of logic-cell flip-flops in the shared bank.
REQ-002 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-003 QCK  input  1  clock; all state changes on rising edge.
REQ-004 QRT  input  1  reset; synchronous, active-high.
REQ-005 req  input  NREQ  per-requester operation request.
REQ-006 op  input  2*NREQ  per-requester opcode: 00 LOAD, 01 SET, 10 CLR, 11 RECIRC.
REQ-007 wdata  input  WIDTH*NREQ  per-requester load data.
REQ-008 lock  input  NREQ  per-requester grant-hold request; present only when Q_FRAG_ARB_LOCK_EN is defined.
REQ-009 gnt  output  NREQ  one-hot grant, asserted during the ISSUE cycle.
REQ-010 ack  output  NREQ  one-hot completion pulse, asserted during the ACK cycle.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 q_en, q_ds, q_st, q_rt  output  1 each  registered bank controls (enable, QDI/CZI select, set, reset).
REQ-013 q_di  output  WIDTH  registered bank load data.

Function
REQ-014 FSM states: IDLE, ISSUE, ACK.
REQ-015 IDLE: if any req is high, arbitrate, capture the winner's op/wdata and go to ISSUE; otherwise stay in IDLE.
REQ-016 Arbitration is round-robin from pointer ptr; the winner is the first asserted req at index ptr, ptr+1, ... modulo NREQ.
REQ-017 ISSUE lasts exactly one cycle: gnt[winner]=1 and bank controls driven per op; ptr <= winner+1 mod NREQ.
REQ-018 Op encoding in ISSUE:
- LOAD: q_en=1, q_ds=1, q_di=captured data.
- SET: q_st=1.
- CLR: q_rt=1.
- RECIRC: q_en=1, q_ds=0.
REQ-019 ACK lasts exactly one cycle: ack[winner]=1, all bank controls 0, giving a settle cycle so set/reset release before the next op.
REQ-020 ACK: if any req is high, arbitrate (REQ-016) and go to ISSUE; otherwise go to IDLE.
REQ-021 Throughput is at most one op per 2 cycles; latency from req sampled in IDLE to gnt is 1 cycle and to ack is 2 cycles.
REQ-022 q_st and q_rt are never asserted together, and never in the same cycle as q_en.
REQ-023 In ACK, the winner is masked from arbitration unless no other req is high (no back-to-back grant while others wait).
REQ-024 Deasserting req after capture does not cancel the op; it completes and is acked.
REQ-025 Changing op/wdata after capture has no effect on the issued op.
REQ-026 Outside ISSUE, gnt=0 and all bank controls are 0; outside ACK, ack=0.

Reset
REQ-027 While QRT is high: state=IDLE, ptr=0, and gnt, ack, busy, q_en, q_ds, q_st, q_rt, q_di are all 0 on the next edge.
REQ-028 Reset during ISSUE or ACK aborts the op; no ack is issued for it.
REQ-029 No lock counter survives reset.

Configuration
REQ-030 Macro Q_FRAG_ARB_LOCK_EN:
- Defined: in ACK, if the winner has req and lock high, it is re-granted regardless of ptr and REQ-023, and ptr is not advanced. A 2-bit counter limits this to 4 consecutive grants, after which normal arbitration is forced for one round.
- Undefined: the lock port and counter are absent and arbitration is purely REQ-016/REQ-023.

Structure
REQ-031 Package q_frag_pkg holds the op enum (LOAD/SET/CLR/RECIRC), the state enum (IDLE/ISSUE/ACK) and the LOCK_MAX=4 constant.
REQ-032 One sub-module, q_frag_rr_pick: combinational round-robin picker (req, ptr, mask in; one-hot winner and index out).

Verification
REQ-033 Bench covers these directed scenarios:
- Reset, then req=0001 op0=LOAD wdata0=0xA5 -> cycle+1: gnt=0001, q_en=1, q_ds=1, q_di=0xA5; cycle+2: ack=0001, controls 0; then IDLE.
- req=1111 held continuously, ptr=0 -> grants 0001, 0010, 0100, 1000, 0001 every 2 cycles.
- op SET then CLR from requester 2 -> q_st pulses one cycle, later q_rt one cycle, never overlapping, with an ACK cycle between them.
- QRT asserted during ISSUE of a CLR -> next cycle all outputs 0, state IDLE, no ack.
- LOCK_EN build, requester 1 holds lock with req=1111 -> requester 1 granted 4 consecutive times, then requester 2 granted.
- req dropped in the ISSUE cycle -> ack still pulses; changing wdata after capture leaves q_di unchanged.
